// File: rtl/branch_predict_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : branch_predict_ctrl
//  Purpose  : Direct-mapped 2-bit saturating-counter branch predictor with
//             EX-stage resolution, one-cycle flush/redirect sequencing and
//             saturating branch/mispredict statistics.
//  Revision : 1.0  initial release
// ============================================================================
module branch_predict_ctrl #(
  parameter int IDX_BITS = 4,
  parameter int XLEN     = 32,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,            // asynchronous, active-low
  input  logic [XLEN-1:0]  if_pc,
  input  logic             if_is_branch,
  output logic             pred_taken,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_is_jump,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic             ex_pred_taken,
  input  logic             ex_r,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             stall,
  output logic             flush,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] misp_cnt
);

  localparam int         ENTRIES     = 1 << IDX_BITS;
  localparam logic [1:0] C_WEAK_NT   = 2'b01;
  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         table_q [ENTRIES];
  logic [1:0]         table_d [ENTRIES];
  logic               flush_q, flush_d;
  logic [XLEN-1:0]    redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0]   br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0]   misp_cnt_q, misp_cnt_d;

  logic [IDX_BITS-1:0] w_if_idx;
  logic [IDX_BITS-1:0] w_ex_idx;
  logic                w_res;
  logic                w_actual_taken;
  logic                w_mispredict;
  logic                w_tbl_upd;

  // Only the index bits of the fetch PC select an entry; the rest are ignored.
  logic w_unused_pc_bits;
  assign w_unused_pc_bits = ^{if_pc[XLEN-1:IDX_BITS+2], if_pc[1:0]};

  assign w_if_idx = if_pc[IDX_BITS+1:2];
  assign w_ex_idx = ex_pc[IDX_BITS+1:2];

  // Zero-latency prediction from the registered table (no write bypass).
  assign pred_taken = if_is_branch & table_q[w_if_idx][1];

  // Resolution decode: jumps take precedence over branches and are always taken.
  always_comb begin
    w_res          = (state_q == RUN) & ex_valid & ~stall & (ex_is_branch | ex_is_jump);
    w_actual_taken = ex_is_jump | ex_r;
    w_mispredict   = w_res & (w_actual_taken != ex_pred_taken);
    w_tbl_upd      = w_res & ex_is_branch & ~ex_is_jump;
  end

  // Next-state for the FSM, table, redirect target and statistics.
  always_comb begin
    state_d       = state_q;
    flush_d       = 1'b0;
    redirect_pc_d = redirect_pc_q;
    br_cnt_d      = br_cnt_q;
    misp_cnt_d    = misp_cnt_q;
    table_d       = table_q;

    case (state_q)
      RUN: begin
        if (w_mispredict) begin
          state_d       = FLUSH;
          flush_d       = 1'b1;
          redirect_pc_d = w_actual_taken ? ex_target : (ex_pc + XLEN'(4));
        end
      end
      FLUSH: begin
        // Flush is not stallable: always back to RUN after one cycle.
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    if (w_tbl_upd) begin
      if (ex_r) begin
        if (table_q[w_ex_idx] != 2'b11) table_d[w_ex_idx] = table_q[w_ex_idx] + 2'd1;
      end else begin
        if (table_q[w_ex_idx] != 2'b00) table_d[w_ex_idx] = table_q[w_ex_idx] - 2'd1;
      end
    end

    if (w_res && (br_cnt_q != C_CNT_MAX))
      br_cnt_d = br_cnt_q + CNT_W'(1);
    if (w_mispredict && (misp_cnt_q != C_CNT_MAX))
      misp_cnt_d = misp_cnt_q + CNT_W'(1);
  end

  // State, table and statistics registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= RUN;
      flush_q       <= 1'b0;
      redirect_pc_q <= '0;
      br_cnt_q      <= '0;
      misp_cnt_q    <= '0;
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= C_WEAK_NT;
    end else begin
      state_q       <= state_d;
      flush_q       <= flush_d;
      redirect_pc_q <= redirect_pc_d;
      br_cnt_q      <= br_cnt_d;
      misp_cnt_q    <= misp_cnt_d;
      table_q       <= table_d;
    end
  end

  assign flush       = flush_q;
  assign redirect_pc = redirect_pc_q;
  assign br_cnt      = br_cnt_q;
  assign misp_cnt    = misp_cnt_q;

endmodule
`default_nettype wire
